// File: rtl/slide_move_gen.sv
// Blank-tile move generator for a 2x4 sliding puzzle. It keeps a shadow board and issues legal from/to moves.
// Optional feature: define SLIDE_NOBACKTRACK_EN to reject the exact reverse of the last acknowledged move.
module slide_move_gen (
  input  logic       clock,
  input  logic       reset,
  input  logic       dir_valid,
  input  logic [1:0] dir,
  output logic       dir_ready,
  output logic       move_valid,
  output logic [2:0] from,
  output logic [2:0] to,
  input  logic       move_ack,
  output logic       reject,
  output logic [2:0] blank,
  output logic       solved,
  output logic [7:0] move_count,
  output logic       state_dbg
);

  // Handshakes: a direction transfers on a posedge with dir_valid && dir_ready;
  // a move transfers on a posedge with move_valid && move_ack. from/to are held while move_valid is high.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t     state, next_state;
  logic [2:0] shadow [8];
  logic [2:0] cand_from;
  logic       geo_legal;
  logic       back_move;
  logic       accept;
  logic       legal;
  logic       take;

  assign accept     = dir_valid && (state == IDLE);
  assign take       = (state == ISSUE) && move_ack;
  assign legal      = geo_legal && !back_move;
  assign dir_ready  = (state == IDLE);
  assign move_valid = (state == ISSUE);
  assign state_dbg  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && legal) next_state = ISSUE;
      ISSUE:   if (move_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Index bit 2 is the row, bits 1:0 the column.
  always_comb begin
    geo_legal = 1'b0;
    cand_from = blank;
    case (dir)
      2'd0: begin geo_legal = blank[2];            cand_from = {1'b0, blank[1:0]}; end
      2'd1: begin geo_legal = !blank[2];           cand_from = {1'b1, blank[1:0]}; end
      2'd2: begin geo_legal = (blank[1:0] != 2'd0); cand_from = blank - 3'd1;      end
      default: begin geo_legal = (blank[1:0] != 2'd3); cand_from = blank + 3'd1;   end
    endcase
  end

`ifdef SLIDE_NOBACKTRACK_EN
  logic [1:0] last_dir;
  logic [1:0] pend_dir;
  logic       last_valid;

  // Up/down and left/right differ only in bit 0.
  assign back_move = last_valid && (dir == (last_dir ^ 2'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_dir   <= 2'd0;
      pend_dir   <= 2'd0;
      last_valid <= 1'b0;
    end else begin
      if (accept && legal) pend_dir <= dir;
      if (take) begin
        last_dir   <= pend_dir;
        last_valid <= 1'b1;
      end
    end
  end
`else
  assign back_move = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reject     <= 1'b0;
      from       <= 3'd0;
      to         <= 3'd0;
      blank      <= 3'd0;
      move_count <= 8'd0;
      for (int i = 0; i < 8; i++) shadow[i] <= 3'(i);
    end else begin
      reject <= accept && !legal;
      if (accept && legal) begin
        from <= cand_from;
        to   <= blank;
      end
      if (take) begin
        shadow[to]   <= shadow[from];
        shadow[from] <= 3'd0;
        blank        <= from;
        if (move_count != 8'd255) move_count <= move_count + 8'd1;
      end
    end
  end

  always_comb begin
    solved = 1'b1;
    for (int i = 0; i < 8; i++)
      if (shadow[i] != 3'(i)) solved = 1'b0;
  end

endmodule

// File: tb/tb_slide_move_gen.sv
// Self-checking bench for slide_move_gen: directed scenarios plus random directions against a board model.
module tb_slide_move_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dir_valid = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       dir_ready;
  logic       move_valid;
  logic [2:0] from;
  logic [2:0] to;
  logic       move_ack = 1'b0;
  logic       reject;
  logic [2:0] blank;
  logic       solved;
  logic [7:0] move_count;
  logic       state_dbg;

  int total = 0;
  int bad = 0;

  // Reference model: tile values per cell, 0 is the blank tile.
  int m_board [8];
  int m_blank;
  int m_count;
  int m_last;

  always #5 clock = ~clock;

  slide_move_gen dut (
    .clock(clock), .reset(reset), .dir_valid(dir_valid), .dir(dir),
    .dir_ready(dir_ready), .move_valid(move_valid), .from(from), .to(to),
    .move_ack(move_ack), .reject(reject), .blank(blank), .solved(solved),
    .move_count(move_count), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_solved();
    for (int i = 0; i < 8; i++) if (m_board[i] != i) return 0;
    return 1;
  endfunction

  function automatic int reverse_of(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_board[i] = i;
    m_blank = 0;
    m_count = 0;
    m_last  = -1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    dir_valid = 1'b0;
    move_ack = 1'b0;
    model_reset();
    @(negedge clock);
    check("rst_move_valid", move_valid, 0);
    check("rst_reject", reject, 0);
    check("rst_blank", blank, 0);
    check("rst_count", move_count, 0);
    check("rst_solved", solved, 1);
    check("rst_from_to", {from, to}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_dir_ready", dir_ready, 1);
  endtask

  // Entered and left at a negedge; hold = cycles to keep move_ack low while the move is offered.
  task automatic apply_dir(input int d, input int hold);
    int row, col, f, ok;
    row = m_blank / 4;
    col = m_blank % 4;
    ok = 0;
    f = 0;
    case (d)
      0: begin ok = (row == 1); f = m_blank - 4; end
      1: begin ok = (row == 0); f = m_blank + 4; end
      2: begin ok = (col != 0); f = m_blank - 1; end
      default: begin ok = (col != 3); f = m_blank + 1; end
    endcase
`ifdef SLIDE_NOBACKTRACK_EN
    if (m_last >= 0 && d == reverse_of(m_last)) ok = 0;
`endif
    dir_valid = 1'b1;
    dir = 2'(d);
    @(negedge clock);
    dir_valid = 1'b0;
    if (ok != 0) begin
      check("issue_valid", move_valid, 1);
      check("issue_from", from, f);
      check("issue_to", to, m_blank);
      check("issue_dir_ready", dir_ready, 0);
      for (int k = 0; k < hold; k++) begin
        dir_valid = 1'($urandom_range(0, 1));
        dir = 2'($urandom_range(0, 3));
        @(negedge clock);
        check("hold_valid", move_valid, 1);
        check("hold_from", from, f);
        check("hold_to", to, m_blank);
        check("hold_dir_ready", dir_ready, 0);
        check("hold_reject", reject, 0);
      end
      dir_valid = 1'b0;
      move_ack = 1'b1;
      @(negedge clock);
      move_ack = 1'b0;
      m_board[m_blank] = m_board[f];
      m_board[f] = 0;
      m_blank = f;
      if (m_count < 255) m_count++;
      m_last = d;
      check("done_valid", move_valid, 0);
      check("done_dir_ready", dir_ready, 1);
      check("done_blank", blank, m_blank);
      check("done_count", move_count, m_count);
      check("done_solved", solved, m_solved());
    end else begin
      check("rej_pulse", reject, 1);
      check("rej_move_valid", move_valid, 0);
      check("rej_blank", blank, m_blank);
      check("rej_count", move_count, m_count);
      @(negedge clock);
      check("rej_one_cycle", reject, 0);
      check("rej_dir_ready", dir_ready, 1);
    end
  endtask

  initial begin
    model_reset();

    // Down then up from reset.
    do_reset();
    apply_dir(1, 0);
    check("down_blank_is_4", blank, 4);
    check("down_unsolved", solved, 0);
    apply_dir(0, 0);
`ifndef SLIDE_NOBACKTRACK_EN
    check("up_back_solved", solved, 1);
    check("up_count_2", move_count, 2);
`else
    check("up_rejected_count", move_count, 1);
`endif

    // Illegal left at cell 0.
    do_reset();
    apply_dir(2, 0);
    check("left_blank_stays", blank, 0);

    // Right with a 5-cycle stall on move_ack.
    do_reset();
    apply_dir(3, 5);
    check("right_blank_1", blank, 1);

    // Reset while a move is pending.
    do_reset();
    dir_valid = 1'b1;
    dir = 2'd3;
    @(negedge clock);
    dir_valid = 1'b0;
    check("pend_valid", move_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_valid_drop", move_valid, 0);
    check("async_solved", solved, 1);
    check("async_blank", blank, 0);
    check("async_state", state_dbg, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("abort_solved", solved, 1);
    check("abort_count", move_count, 0);

    // Saturation with alternating right/left.
    do_reset();
    for (int n = 0; n < 260; n++) apply_dir((n % 2 == 0) ? 3 : 2, 0);
`ifndef SLIDE_NOBACKTRACK_EN
    check("sat_count_255", move_count, 255);
    check("sat_solved", solved, 1);
`endif

    // Random walk.
    do_reset();
    for (int n = 0; n < 200; n++) apply_dir(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slide_move_gen.md
SLIDE_MOVE_GEN -- requirements
Module: slide_move_gen

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: dir_valid  input  1  direction request present.
REQ-004 SHALL have port: dir  input  2  blank-cell direction: 0=up, 1=down, 2=left, 3=right.
REQ-005 SHALL have port: dir_ready  output  1  ready to accept a direction.
REQ-006 SHALL have port: move_valid  output  1  a move is presented on from/to.
REQ-007 SHALL have port: from  output  3  source cell index of the move; this cell is the blank's new position.
REQ-008 SHALL have port: to  output  3  destination cell index, always the current blank cell.
REQ-009 SHALL have port: move_ack  input  1  puzzle has taken the move.
REQ-010 SHALL have port: reject  output  1  one-cycle pulse when a direction is illegal.
REQ-011 SHALL have port: blank  output  3  current blank cell index.
REQ-012 SHALL have port: solved  output  1  shadow board equals identity.
REQ-013 SHALL have port: move_count  output  8  accepted-and-acknowledged moves, saturating.

Function
REQ-014 SHALL drive the 2x4 board with cells 0-3 in row 0 and 4-7 in row 1; index bit 2 is the row and bits 1:0 are the column.
REQ-015 SHALL keep a shadow board of 8 cells, 3 bits each, plus a blank index.
REQ-016 SHALL use a two-state FSM: IDLE (dir_ready=1, move_valid=0) and ISSUE (dir_ready=0, move_valid=1).
REQ-017 SHALL accept a direction on a posedge where dir_valid && dir_ready.
REQ-018 SHALL define the legal moves as follows: up needs blank row 1, from=blank-4; down needs row 0, from=blank+4; left needs col!=0, from=blank-1; right needs col!=3, from=blank+1.
REQ-019 SHALL, on a legal accepted direction, register from, set to=blank and enter ISSUE on the same edge, so move_valid is high in the next cycle.
REQ-020 SHALL, on an illegal accepted direction, stay in IDLE, pulse reject high for exactly the following cycle, and leave all other state unchanged.
REQ-021 SHALL hold from and to stable while move_valid=1; dir inputs are ignored in ISSUE.
REQ-022 SHALL, on a posedge with move_valid && move_ack: set shadow[to] to shadow[from], clear shadow[from] to 0, set blank to from, increment move_count, and return to IDLE.
REQ-023 SHALL saturate move_count at 255; further moves still execute.
REQ-024 SHALL compute solved combinationally as shadow[i]==i for all i.
REQ-025 SHALL produce from/to pairs that always satisfy the puzzle's adjacency-and-blank validity predicate.

Reset
REQ-026 SHALL, on reset assertion, immediately put the block in IDLE with move_valid=0, reject=0, from=0, to=0, blank=0, move_count=0, and shadow[i]=i (so solved=1).
REQ-027 SHALL, on reset asserted during ISSUE, abort the pending move without updating the shadow board.
REQ-028 SHALL raise dir_ready on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, when SLIDE_NOBACKTRACK_EN is defined, record the direction of the last acknowledged move.
REQ-030 SHALL, with SLIDE_NOBACKTRACK_EN defined, treat the exact reverse of that direction as illegal and issue reject (up/down and left/right are reverse pairs); reset clears the record.
REQ-031 SHALL, without SLIDE_NOBACKTRACK_EN, accept reverse moves and instantiate no recording logic.

Verification
REQ-032 SHALL pass: after reset, apply dir=1 (down) and ack -> from=4, to=0; then blank=4, shadow[0]=4, shadow[4]=0, solved=0, move_count=1.
REQ-033 SHALL pass: continuing, apply dir=0 (up) -> without the macro: from=0, to=4; after ack solved=1 and move_count=2. With the macro: reject pulses for 1 cycle and move_count stays 1.
REQ-034 SHALL pass: after reset, apply dir=2 (left) -> reject=1 for one cycle, move_valid stays 0, blank stays 0.
REQ-035 SHALL pass: after reset, apply dir=3 (right) and hold move_ack=0 for 5 cycles -> move_valid, from=1 and to=0 stay stable and dir_ready=0; ack then gives blank=1.
REQ-036 SHALL pass: assert reset while in ISSUE -> move_valid falls without a clock edge and the shadow board stays identity.
REQ-037 SHALL pass: 260 alternating right/left moves without the macro -> move_count=255 and the board returns to solved.
